// File: rtl/survivor_ring_mem.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : survivor_ring_mem
// Purpose  : Circular survivor-path memory for a Viterbi decoder. The ACS unit
//            writes at an auto-incrementing pointer; traceback reads by offset.
// Revision : 1.0 - initial release
// ============================================================================
module survivor_ring_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6,
    parameter int RDW_MODE   = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_offset,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  rd_err,
    output logic [ADDR_WIDTH-1:0] wr_ptr,
    output logic [ADDR_WIDTH:0]   fill_count,
    output logic                  full
);

    localparam int                  DEPTH        = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] C_FILL_MAX   = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] C_OLDEST   = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] C_ONE      = ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] mem_rd_q;

    logic [ADDR_WIDTH-1:0] wr_ptr_q,   wr_ptr_d;
    logic [ADDR_WIDTH:0]   fill_q,     fill_d;
    logic                  full_q,     full_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  rd_err_q,   rd_err_d;
    logic [DATA_WIDTH-1:0] hold_q,     hold_d;
    logic                  byp_q;
    logic [DATA_WIDTH-1:0] byp_data_q;

    logic                  w_wr_fire;
    logic                  w_rd_fire;
    logic [ADDR_WIDTH-1:0] w_rd_addr;
    logic                  w_rd_oob;
    logic                  w_collide;
    logic [DATA_WIDTH-1:0] w_rd_data;

    assign w_wr_fire = wr_en  & ~clear;
    assign w_rd_fire = rd_req & ~clear;
    assign w_rd_addr = wr_ptr_q - C_ONE - rd_offset;
    assign w_rd_oob  = ({1'b0, rd_offset} >= fill_q);
    // Offset DEPTH-1 on a full ring addresses exactly the slot being overwritten.
    assign w_collide = full_q & w_wr_fire & (rd_offset == C_OLDEST);

    // RAM array: read-first, no reset, so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (w_wr_fire) begin
            mem[wr_ptr_q] <= wr_data;
        end
        if (w_rd_fire) begin
            mem_rd_q <= mem[w_rd_addr];
        end
    end

    generate
        if (RDW_MODE == 1) begin : g_bypass
            logic                  byp_d;
            logic [DATA_WIDTH-1:0] byp_data_d;

            always_comb begin
                byp_d      = w_rd_fire & w_collide;
                byp_data_d = byp_d ? wr_data : byp_data_q;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    byp_q      <= 1'b0;
                    byp_data_q <= '0;
                end else begin
                    byp_q      <= byp_d;
                    byp_data_q <= byp_data_d;
                end
            end
        end else begin : g_no_bypass
            assign byp_q      = 1'b0;
            assign byp_data_q = '0;
        end
    endgenerate

    // Out-of-window reads return zero; idle cycles replay the last presented word.
    always_comb begin
        w_rd_data = hold_q;
        if (rd_valid_q) begin
            if (rd_err_q) begin
                w_rd_data = '0;
            end else if (byp_q) begin
                w_rd_data = byp_data_q;
            end else begin
                w_rd_data = mem_rd_q;
            end
        end
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        fill_d     = fill_q;
        rd_valid_d = 1'b0;
        rd_err_d   = 1'b0;
        hold_d     = w_rd_data;

        if (clear) begin
            wr_ptr_d = '0;
            fill_d   = '0;
        end else begin
            if (w_wr_fire) begin
                wr_ptr_d = wr_ptr_q + C_ONE;
                if (!full_q) begin
                    fill_d = fill_q + 1'b1;
                end
            end
            if (w_rd_fire) begin
                rd_valid_d = 1'b1;
                rd_err_d   = w_rd_oob;
            end
        end
        full_d = (fill_d == C_FILL_MAX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            fill_q     <= '0;
            full_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
            hold_q     <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            fill_q     <= fill_d;
            full_q     <= full_d;
            rd_valid_q <= rd_valid_d;
            rd_err_q   <= rd_err_d;
            hold_q     <= hold_d;
        end
    end

    assign rd_data    = w_rd_data;
    assign rd_valid   = rd_valid_q;
    assign rd_err     = rd_err_q;
    assign wr_ptr     = wr_ptr_q;
    assign fill_count = fill_q;
    assign full       = full_q;

endmodule
`default_nettype wire

// File: tb/tb_survivor_ring_mem.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_survivor_ring_mem
// Purpose  : Scoreboard bench driving both read-during-write variants in lockstep.
// Revision : 1.0 - initial release
// ============================================================================
module tb_survivor_ring_mem;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clear = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = '0;
    logic       rd_req = 1'b0;
    logic [5:0] rd_offset = '0;

    logic [7:0] rd_data0, rd_data1;
    logic       rd_valid0, rd_valid1, rd_err0, rd_err1, full0, full1;
    logic [5:0] wr_ptr0, wr_ptr1;
    logic [6:0] fill0, fill1;

    int checks = 0;
    int failures = 0;
    logic [8:0] q0[$];
    logic [8:0] q1[$];

    always #5 clk = ~clk;

    survivor_ring_mem #(.DATA_WIDTH(8), .ADDR_WIDTH(6), .RDW_MODE(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .wr_en(wr_en), .wr_data(wr_data),
        .rd_req(rd_req), .rd_offset(rd_offset), .rd_data(rd_data0), .rd_valid(rd_valid0),
        .rd_err(rd_err0), .wr_ptr(wr_ptr0), .fill_count(fill0), .full(full0)
    );

    survivor_ring_mem #(.DATA_WIDTH(8), .ADDR_WIDTH(6), .RDW_MODE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .wr_en(wr_en), .wr_data(wr_data),
        .rd_req(rd_req), .rd_offset(rd_offset), .rd_data(rd_data1), .rd_valid(rd_valid1),
        .rd_err(rd_err1), .wr_ptr(wr_ptr1), .fill_count(fill1), .full(full1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: every presented read response is matched against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("err_without_valid0", {31'd0, rd_err0 & ~rd_valid0}, 32'd0);
            if (rd_valid0) begin
                if (q0.size() == 0) begin
                    chk("unexpected_valid0", 32'd1, 32'd0);
                end else begin
                    chk("rd_resp0", {23'd0, rd_err0, rd_data0}, {23'd0, q0.pop_front()});
                end
            end
            if (rd_valid1) begin
                if (q1.size() == 0) begin
                    chk("unexpected_valid1", 32'd1, 32'd0);
                end else begin
                    chk("rd_resp1", {23'd0, rd_err1, rd_data1}, {23'd0, q1.pop_front()});
                end
            end
        end
    end

    task automatic step(input logic we, input logic [7:0] wd, input logic rq,
                        input logic [5:0] off, input logic clr);
        wr_en = we; wr_data = wd; rd_req = rq; rd_offset = off; clear = clr;
        @(posedge clk);
        #1;
        wr_en = 1'b0; rd_req = 1'b0; clear = 1'b0;
    endtask

    task automatic rd(input logic [5:0] off, input logic [7:0] e0, input logic [7:0] e1,
                      input logic err);
        q0.push_back({err, e0});
        q1.push_back({err, e1});
        step(1'b0, 8'h00, 1'b1, off, 1'b0);
    endtask

    task automatic status(input string name, input logic [5:0] ptr, input logic [6:0] fill,
                          input logic f);
        chk({name, "_ptr0"},  {26'd0, wr_ptr0}, {26'd0, ptr});
        chk({name, "_fill0"}, {25'd0, fill0},   {25'd0, fill});
        chk({name, "_full0"}, {31'd0, full0},   {31'd0, f});
        chk({name, "_ptr1"},  {26'd0, wr_ptr1}, {26'd0, ptr});
        chk({name, "_fill1"}, {25'd0, fill1},   {25'd0, fill});
        chk({name, "_full1"}, {31'd0, full1},   {31'd0, f});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        status("reset", 6'd0, 7'd0, 1'b0);
        chk("reset_valid0", {31'd0, rd_valid0}, 32'd0);
        chk("reset_data0", {24'd0, rd_data0}, 32'd0);

        // Empty ring: any read is out of window.
        rd(6'd0, 8'h00, 8'h00, 1'b1);

        for (int i = 1; i <= 10; i++) step(1'b1, 8'(i), 1'b0, 6'd0, 1'b0);
        status("fill10", 6'd10, 7'd10, 1'b0);
        rd(6'd0,  8'h0A, 8'h0A, 1'b0);
        rd(6'd9,  8'h01, 8'h01, 1'b0);
        rd(6'd10, 8'h00, 8'h00, 1'b1);
        rd(6'd5,  8'h05, 8'h05, 1'b0);

        // Clear wins over a simultaneous write and read.
        step(1'b1, 8'hEE, 1'b1, 6'd0, 1'b1);
        status("clear", 6'd0, 7'd0, 1'b0);
        chk("clear_valid0", {31'd0, rd_valid0}, 32'd0);
        chk("clear_hold0", {24'd0, rd_data0}, 32'h05);
        chk("clear_hold1", {24'd0, rd_data1}, 32'h05);
        rd(6'd0, 8'h00, 8'h00, 1'b1);

        for (int i = 0; i < 70; i++) begin
            step(1'b1, 8'(i), 1'b0, 6'd0, 1'b0);
            chk("wrap_fill0", {25'd0, fill0}, (i + 1 > 64) ? 32'd64 : 32'(i + 1));
            if (i == 63) status("wrap64", 6'd0, 7'd64, 1'b1);
        end
        status("wrap70", 6'd6, 7'd64, 1'b1);
        rd(6'd0,  8'd69, 8'd69, 1'b0);
        rd(6'd1,  8'd68, 8'd68, 1'b0);
        rd(6'd63, 8'd6,  8'd6,  1'b0);

        // Collision: oldest slot (addr 6, holding 6) overwritten while read.
        q0.push_back({1'b0, 8'h06});
        q1.push_back({1'b0, 8'hAA});
        step(1'b1, 8'hAA, 1'b1, 6'd63, 1'b0);
        status("collide", 6'd7, 7'd64, 1'b1);
        rd(6'd0,  8'hAA, 8'hAA, 1'b0);
        rd(6'd63, 8'd7,  8'd7,  1'b0);

        // Async reset while a read request is pending.
        rd_req = 1'b1; rd_offset = 6'd0;
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        status("async_rst", 6'd0, 7'd0, 1'b0);
        chk("async_valid0", {31'd0, rd_valid0}, 32'd0);
        chk("async_data0", {24'd0, rd_data0}, 32'd0);
        @(posedge clk);
        #1 rd_req = 1'b0;
        chk("abort_valid0", {31'd0, rd_valid0}, 32'd0);
        rst_n = 1'b1;
        step(1'b0, 8'h00, 1'b0, 6'd0, 1'b0);
        chk("abort_valid1", {31'd0, rd_valid1}, 32'd0);
        status("post_rst", 6'd0, 7'd0, 1'b0);

        repeat (2) step(1'b0, 8'h00, 1'b0, 6'd0, 1'b0);
        chk("drain_q0", 32'(q0.size()), 32'd0);
        chk("drain_q1", 32'(q1.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
